// File: rtl/slot_sensor_debouncer.sv
// Per-slot sensor debouncer: prescaled sample tick, per-slot persistence counters,
// arrive/depart pulses, occupied count and startup ready. Define SENSOR_SYNC_EN for 2-flop input sync.
module slot_sensor_debouncer_lane #(
  parameter int DB_TICKS = 8,
  parameter int DBW      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic tick,
  output logic car,
  output logic arrive,
  output logic depart
);
  logic [DBW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      car    <= 1'b0;
      arrive <= 1'b0;
      depart <= 1'b0;
    end else begin
      arrive <= 1'b0;
      depart <= 1'b0;
      // Any cycle back at the accepted level throws away the partial count.
      if (s == car) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == DBW'(DB_TICKS - 1)) begin
          car    <= s;
          cnt    <= '0;
          arrive <= s;
          depart <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module slot_sensor_debouncer #(
  parameter int N_SLOTS  = 15,
  parameter int TICK_DIV = 100000,
  parameter int DB_TICKS = 8,
  parameter int CNT_W    = $clog2(N_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SLOTS-1:0] sensor_raw,
  output logic [N_SLOTS-1:0] cars,
  output logic [N_SLOTS-1:0] arrive,
  output logic [N_SLOTS-1:0] depart,
  output logic [CNT_W-1:0]   occupied_count,
  output logic               ready
);
  localparam int PW  = $clog2(TICK_DIV);
  localparam int DBW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

  logic [N_SLOTS-1:0] s;
  logic [PW-1:0]      presc;
  logic               tick;
  logic [DBW-1:0]     rdy_cnt;
  logic [CNT_W-1:0]   pop;

`ifdef SENSOR_SYNC_EN
  logic [N_SLOTS-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end
  assign s = sync2;
`else
  assign s = sensor_raw;
`endif

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Settle window: same DB_TICKS tick budget a slot needs to accept a level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_cnt <= '0;
      ready   <= 1'b0;
    end else if (tick && !ready) begin
      if (rdy_cnt == DBW'(DB_TICKS - 1)) ready <= 1'b1;
      else rdy_cnt <= rdy_cnt + 1'b1;
    end
  end

  slot_sensor_debouncer_lane #(.DB_TICKS(DB_TICKS), .DBW(DBW)) u_lane [N_SLOTS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .s      (s),
    .tick   (tick),
    .car    (cars),
    .arrive (arrive),
    .depart (depart)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SLOTS; i++) pop = pop + CNT_W'(cars[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occupied_count <= '0;
    else occupied_count <= pop;
  end
endmodule
